// File: rtl/fetch_if.sv
// Bundle between the fetch stage and its surroundings: hazard/branch control in,
// instruction-memory address/data, and the IF/ID pipeline register out.
interface fetch_if;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] inst_addr;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        valid_out;
    logic [31:0] fetch_count;
    logic [31:0] flush_count;

    modport master (
        output freeze,
        output branch_taken,
        output branch_addr,
        input  inst_addr,
        output instruction,
        input  pc_out,
        input  inst_out,
        input  valid_out,
        input  fetch_count,
        input  flush_count
    );

    modport slave (
        input  freeze,
        input  branch_taken,
        input  branch_addr,
        output inst_addr,
        input  instruction,
        output pc_out,
        output inst_out,
        output valid_out,
        output fetch_count,
        output flush_count
    );
endinterface

// File: rtl/fetch_stage.sv
// ARM instruction-fetch stage: PC register, instruction-memory addressing and the IF/ID register.
// Optional macro FETCH_STATS_EN adds fetch/flush statistics counters (tied to 0 otherwise).
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'hE000_0000
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FROZEN   = 2'd1,
        ST_REDIRECT = 2'd2
    } st_e;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_sel_e;

    st_e         st_r;
    st_e         st_nxt_s;
    ifid_sel_e   ifid_sel_s;

    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] pc_inc_s;
    logic [31:0] pc_tgt_s;
    logic [31:0] pc_out_r;
    logic [31:0] inst_out_r;
    logic        valid_r;

    assign pc_inc_s      = pc_r + 32'd4;
    assign pc_tgt_s      = bus.branch_addr & 32'hFFFF_FFFC;
    assign bus.inst_addr = {2'b00, pc_r[31:2]};
    assign bus.pc_out    = pc_out_r;
    assign bus.inst_out  = inst_out_r;
    assign bus.valid_out = valid_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            st_r <= ST_RUN;
        end else begin
            st_r <= st_nxt_s;
        end
    end

    // FSM next state: a branch always wins, then freeze, else normal fetch
    always_comb begin
        st_nxt_s = ST_RUN;
        if (bus.branch_taken) begin
            st_nxt_s = ST_REDIRECT;
        end else if (bus.freeze) begin
            st_nxt_s = ST_FROZEN;
        end else begin
            st_nxt_s = ST_RUN;
        end
    end

    // FSM outputs: PC source and IF/ID action
    always_comb begin
        pc_nxt_s   = pc_r;
        ifid_sel_s = IFID_HOLD;
        if (bus.branch_taken) begin
            pc_nxt_s   = pc_tgt_s;
            ifid_sel_s = IFID_BUBBLE;
        end else if (bus.freeze) begin
            pc_nxt_s   = pc_r;
            // A freeze during redirect must keep the bubble; rewrite it rather than trust the hold.
            ifid_sel_s = (st_r == ST_REDIRECT) ? IFID_BUBBLE : IFID_HOLD;
        end else begin
            pc_nxt_s   = pc_inc_s;
            ifid_sel_s = IFID_LOAD;
        end
    end

    // PC and IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            inst_out_r <= NOP_WORD;
            pc_out_r   <= 32'd0;
            valid_r    <= 1'b0;
        end else begin
            pc_r <= pc_nxt_s;
            case (ifid_sel_s)
                IFID_LOAD: begin
                    inst_out_r <= bus.instruction;
                    pc_out_r   <= pc_inc_s;
                    valid_r    <= 1'b1;
                end
                IFID_BUBBLE: begin
                    inst_out_r <= NOP_WORD;
                    pc_out_r   <= 32'd0;
                    valid_r    <= 1'b0;
                end
                default: begin
                    inst_out_r <= inst_out_r;
                    pc_out_r   <= pc_out_r;
                    valid_r    <= valid_r;
                end
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] flush_cnt_r;

    // Free-running statistics counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (ifid_sel_s == IFID_LOAD) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end else begin
                fetch_cnt_r <= fetch_cnt_r;
            end
            if (bus.branch_taken) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign bus.fetch_count = fetch_cnt_r;
    assign bus.flush_count = flush_cnt_r;
`else
    assign bus.fetch_count = 32'd0;
    assign bus.flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage; a second instance with RESET_PC = 0x10
// shares the control stimulus so the reset address can be checked.
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'hE000_0000;
    localparam logic [31:0] BASE = 32'hE3A0_0000;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    fetch_if bus_a ();
    fetch_if bus_b ();

    fetch_stage dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    fetch_stage #(
        .RESET_PC (32'h0000_0010)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Instruction memory model: word i holds BASE + i
    assign bus_a.instruction  = BASE + bus_a.inst_addr;
    assign bus_b.instruction  = BASE + bus_b.inst_addr;
    assign bus_b.freeze       = bus_a.freeze;
    assign bus_b.branch_taken = bus_a.branch_taken;
    assign bus_b.branch_addr  = bus_a.branch_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        frz;
        logic        br;
        logic [31:0] baddr;
        logic [31:0] ia;
        logic [31:0] pco;
        logic [31:0] ins;
        logic        vld;
        logic [31:0] fc;
        logic [31:0] flc;
        logic        chk_b;
        logic [31:0] ia_b;
    } vec_t;

    vec_t vecs [22];

    function automatic logic [31:0] w(input logic [31:0] i);
        return BASE + i;
    endfunction

    function automatic logic [31:0] cnt(input logic [31:0] x);
`ifdef FETCH_STATS_EN
        return x;
`else
        return 32'd0 & x;
`endif
    endfunction

    function automatic vec_t mk(input logic r, input logic f, input logic b, input logic [31:0] ba,
                                input logic [31:0] ia, input logic [31:0] pco, input logic [31:0] ins,
                                input logic v, input logic [31:0] fc, input logic [31:0] flc,
                                input logic cb, input logic [31:0] iab);
        vec_t t;
        t.rst = r;   t.frz = f;   t.br = b;    t.baddr = ba;
        t.ia = ia;   t.pco = pco; t.ins = ins; t.vld = v;
        t.fc = cnt(fc); t.flc = cnt(flc); t.chk_b = cb; t.ia_b = iab;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;

        // rst frz br baddr          ia           pco        ins             vld fc flc  chk_b ia_b
        vecs[0]  = mk(1, 0, 0, 32'h0,         32'h0,        32'h0,     NOP,            0, 0, 0, 1, 32'h4);
        vecs[1]  = mk(0, 0, 0, 32'h0,         32'h1,        32'h4,     w(32'h0),       1, 1, 0, 0, 32'h0);
        vecs[2]  = mk(0, 0, 0, 32'h0,         32'h2,        32'h8,     w(32'h1),       1, 2, 0, 0, 32'h0);
        vecs[3]  = mk(0, 0, 1, 32'h13,        32'h4,        32'h0,     NOP,            0, 2, 1, 0, 32'h0);
        vecs[4]  = mk(0, 0, 0, 32'h0,         32'h5,        32'd20,    w(32'h4),       1, 3, 1, 0, 32'h0);
        vecs[5]  = mk(0, 0, 1, 32'h8,         32'h2,        32'h0,     NOP,            0, 3, 2, 0, 32'h0);
        vecs[6]  = mk(0, 0, 0, 32'h0,         32'h3,        32'd12,    w(32'h2),       1, 4, 2, 0, 32'h0);
        vecs[7]  = mk(0, 1, 0, 32'h0,         32'h3,        32'd12,    w(32'h2),       1, 4, 2, 0, 32'h0);
        vecs[8]  = mk(0, 1, 0, 32'h0,         32'h3,        32'd12,    w(32'h2),       1, 4, 2, 0, 32'h0);
        vecs[9]  = mk(0, 1, 0, 32'h0,         32'h3,        32'd12,    w(32'h2),       1, 4, 2, 0, 32'h0);
        vecs[10] = mk(0, 0, 0, 32'h0,         32'h4,        32'd16,    w(32'h3),       1, 5, 2, 0, 32'h0);
        vecs[11] = mk(0, 1, 1, 32'h40,        32'h10,       32'h0,     NOP,            0, 5, 3, 0, 32'h0);
        vecs[12] = mk(0, 0, 1, 32'h80,        32'h20,       32'h0,     NOP,            0, 5, 4, 0, 32'h0);
        vecs[13] = mk(0, 0, 0, 32'h0,         32'h21,       32'h84,    w(32'h20),      1, 6, 4, 0, 32'h0);
        vecs[14] = mk(0, 0, 1, 32'h100,       32'h40,       32'h0,     NOP,            0, 6, 5, 0, 32'h0);
        vecs[15] = mk(0, 1, 0, 32'h0,         32'h40,       32'h0,     NOP,            0, 6, 5, 0, 32'h0);
        vecs[16] = mk(0, 0, 0, 32'h0,         32'h41,       32'h104,   w(32'h40),      1, 7, 5, 0, 32'h0);
        vecs[17] = mk(0, 0, 1, 32'h200,       32'h80,       32'h0,     NOP,            0, 7, 6, 0, 32'h0);
        vecs[18] = mk(1, 0, 1, 32'h300,       32'h0,        32'h0,     NOP,            0, 0, 0, 1, 32'h4);
        vecs[19] = mk(0, 0, 0, 32'h0,         32'h1,        32'h4,     w(32'h0),       1, 1, 0, 0, 32'h0);
        vecs[20] = mk(0, 0, 1, 32'hFFFF_FFFF, 32'h3FFF_FFFF, 32'h0,    NOP,            0, 1, 1, 0, 32'h0);
        vecs[21] = mk(0, 0, 0, 32'h0,         32'h0,        32'h0,     w(32'h3FFF_FFFF), 1, 2, 1, 0, 32'h0);

        for (int i = 0; i < 22; i++) begin
            rst                = vecs[i].rst;
            bus_a.freeze       = vecs[i].frz;
            bus_a.branch_taken = vecs[i].br;
            bus_a.branch_addr  = vecs[i].baddr;
            tick();
            chk("inst_addr",   i, bus_a.inst_addr,   vecs[i].ia);
            chk("pc_out",      i, bus_a.pc_out,      vecs[i].pco);
            chk("inst_out",    i, bus_a.inst_out,    vecs[i].ins);
            chk("valid_out",   i, {31'd0, bus_a.valid_out}, {31'd0, vecs[i].vld});
            chk("fetch_count", i, bus_a.fetch_count, vecs[i].fc);
            chk("flush_count", i, bus_a.flush_count, vecs[i].flc);
            if (vecs[i].chk_b) begin
                chk("b_inst_addr",   i, bus_b.inst_addr,   vecs[i].ia_b);
                chk("b_pc_out",      i, bus_b.pc_out,      32'h0);
                chk("b_inst_out",    i, bus_b.inst_out,    NOP);
                chk("b_valid_out",   i, {31'd0, bus_b.valid_out}, 32'd0);
                chk("b_fetch_count", i, bus_b.fetch_count, 32'd0);
                chk("b_flush_count", i, bus_b.flush_count, 32'd0);
            end
        end

        // Long freeze after the wrap: IF/ID and PC stay put, then resume without skipping
        bus_a.freeze       = 1'b1;
        bus_a.branch_taken = 1'b0;
        bus_a.branch_addr  = 32'h0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("frz_inst_addr",   100 + k, bus_a.inst_addr,   32'h0);
            chk("frz_inst_out",    100 + k, bus_a.inst_out,    w(32'h3FFF_FFFF));
            chk("frz_pc_out",      100 + k, bus_a.pc_out,      32'h0);
            chk("frz_fetch_count", 100 + k, bus_a.fetch_count, cnt(32'd2));
        end
        bus_a.freeze = 1'b0;
        tick();
        chk("rel_inst_addr",   200, bus_a.inst_addr,   32'h1);
        chk("rel_inst_out",    200, bus_a.inst_out,    w(32'h0));
        chk("rel_pc_out",      200, bus_a.pc_out,      32'h4);
        chk("rel_valid_out",   200, {31'd0, bus_a.valid_out}, 32'd1);
        chk("rel_fetch_count", 200, bus_a.fetch_count, cnt(32'd3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the ARM pipeline. Holds the program counter, drives the word address into the instruction memory, and registers each returned instruction with its PC+4 into the IF/ID pipeline register consumed by decode. Supports hazard freeze from the hazard unit and branch redirect/flush from execute.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: byte address of the first fetch after reset.
- `NOP_WORD`, default 32'hE000_0000: bubble encoding (AL-condition, all-zero data-processing) placed in IF/ID on flush and reset.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: reset; synchronous, active-high.
- `freeze`, input, 1: hazard stall; hold the PC and IF/ID.
- `branch_taken`, input, 1: redirect request from execute.
- `branch_addr`, input, 32: byte target address; bits [1:0] are ignored and treated as 0.
- `inst_addr`, output, 32: word index to the instruction memory, `{2'b00, pc[31:2]}`; combinational from the PC register.
- `instruction`, input, 32: instruction word returned combinationally by the memory.
- `pc_out`, output, 32: IF/ID PC+4 of the held instruction.
- `inst_out`, output, 32: IF/ID instruction.
- `valid_out`, output, 1: IF/ID contents are a real instruction, not a bubble.
- `fetch_count`, output, 32: count of instructions accepted into IF/ID (see Configuration).
- `flush_count`, output, 32: count of squashed fetches (see Configuration).

## Operation
- The PC register is byte-addressed. Its next value is computed with this priority:
  - `branch_taken` gives `{branch_addr[31:2], 2'b00}`.
  - Otherwise `freeze` holds the PC.
  - Otherwise PC + 4, wrapping modulo 2^32 (32'hFFFF_FFFC goes to 0).
- IF/ID update, same priority:
  - `branch_taken`: `inst_out` = `NOP_WORD`, `pc_out` = 0, `valid_out` = 0. This squashes the wrong-path word fetched this cycle.
  - `freeze`: all three outputs hold.
  - Otherwise: `inst_out` = `instruction`, `pc_out` = PC + 4, `valid_out` = 1.
- FSM state register `st`, with these states:
  - RUN: normal fetch.
  - FROZEN: entered when `freeze` is high and `branch_taken` is low.
  - REDIRECT: entered for exactly one cycle after `branch_taken`. In this state IF/ID holds the bubble and the target instruction is being fetched.
- FSM transitions:
  - From any state, `branch_taken` goes to REDIRECT.
  - Otherwise, `freeze` goes to FROZEN.
  - Otherwise the next state is RUN.
  - A second `branch_taken` while in REDIRECT restarts the redirect: it inserts one more bubble and loads the new target.
- `freeze` asserted in REDIRECT holds the bubble in IF/ID and the target in the PC.
- Back-to-back `freeze` cycles keep IF/ID stable indefinitely. There is no internal timeout.

## Timing
- Fetch latency: `inst_addr` reflects the PC in the same cycle. The instruction appears on `inst_out` one edge later.
- Branch penalty: one bubble cycle. The edge that samples `branch_taken` writes the bubble and loads the PC with the target. The target instruction appears on `inst_out` on the following edge, provided `freeze` is low.
- Freeze is sampled each edge. Releasing it resumes with the held PC, so no instruction is lost or duplicated.
- Reset (synchronous, overrides all inputs, valid mid-operation or mid-redirect):
  - PC = `RESET_PC`, so `inst_addr` = `RESET_PC` >> 2.
  - `inst_out` = `NOP_WORD`, `pc_out` = 0, `valid_out` = 0.
  - `st` = RUN.
  - `fetch_count` = `flush_count` = 0.
- The first real instruction is on `inst_out` at the first edge after `rst` falls.

## Configuration
- Macro `FETCH_STATS_EN`.
- Defined:
  - `fetch_count` increments on each edge where IF/ID loads with `valid_out` = 1.
  - `flush_count` increments on each edge where `branch_taken` squashes a fetch.
  - Both are 32-bit free-running counters that wrap to 0, are cleared by `rst`, and hold during `freeze` without `branch_taken`.
- Undefined: both ports remain present but are driven constant 0, and no counter flops are synthesized.

## Test plan
- Reset then run with memory word i = 32'hE3A0_0000 + i, for 4 cycles:
  - `inst_addr` steps 0, 1, 2, 3.
  - `inst_out` shows 32'hE3A0_0000 … 32'hE3A0_0003, with `pc_out` 4, 8, 12, 16.
  - `valid_out` = 1 from the first edge after reset.
- Assert `branch_taken` with `branch_addr` = 32'h0000_0013 while the PC is 8:
  - Next edge gives `inst_out` = 32'hE000_0000, `valid_out` = 0, `inst_addr` = 4.
  - The following edge gives word 4 with `pc_out` = 20.
  - `flush_count` = 1 when `FETCH_STATS_EN` is defined.
- Hold `freeze` for 3 cycles at PC 12:
  - `inst_addr` stays 3 and IF/ID stays constant.
  - On release the next edge loads word 3, with no skip or duplicate.
  - `fetch_count` is unchanged during the freeze.
- Assert `freeze` and `branch_taken` together:
  - The branch wins, a bubble is inserted, and the PC takes the target.
  - Then assert `branch_taken` again in REDIRECT: two consecutive bubbles, and the second target is fetched.
- Assert `rst` for 1 cycle mid-redirect with `RESET_PC` = 32'h0000_0010:
  - All outputs take their reset values and `inst_addr` = 4.
  - The counters read 0.
- Wrap: force the PC to 32'hFFFF_FFFC via `branch_taken`, then run 1 cycle. `inst_addr` shows 0 and `pc_out` = 0.
